// File: rtl/segasys1_sprcoll_ram.sv
// segasys1_sprcoll_ram: 1024x1 sprite-collision store for the System 1 sprite path.
// Renderer events are buffered in a small FIFO and set bits; the CPU reads or clears
// single entries. A post-reset sweep zeroes the store. Define SPRCOLL_SUMMARY_EN to
// build the sticky coll_any summary register; otherwise coll_any is tied low.
module segasys1_sprcoll_ram #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       VCLKx4,
    input  logic       RESET_N,
    input  logic       sprcoll,
    input  logic [9:0] sprcoll_ad,
    input  logic       cpu_req,
    input  logic       cpu_wr,
    input  logic [9:0] cpu_ad,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdt,
    output logic       busy,
    output logic       coll_any,
    input  logic       cpu_sum_clr
);

    localparam int unsigned AW        = 10;
    localparam int unsigned RAM_WORDS = 1024;
    localparam int unsigned FAW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW        = FAW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t         state_q;
    logic [AW-1:0]  sweep_q;
    logic           cpu_ack_q;
    logic [7:0]     cpu_rdt_q;
    logic           busy_q;

    logic [AW-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [FAW-1:0] wr_ptr_q;
    logic [FAW-1:0] rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           ovf_q;

    logic           ram_q [RAM_WORDS];

    logic           fifo_empty_c;
    logic           fifo_full_c;
    logic           ev_valid_c;
    logic           pop_c;
    logic           push_c;
    logic           grant_c;
    logic           ram_we_c;
    logic [AW-1:0]  ram_wa_c;
    logic           ram_wd_c;

    // Arbitration of the single RAM port: sweep, then FIFO drain, then CPU clear.
    always_comb begin
        fifo_empty_c = 1'b0;
        fifo_full_c  = 1'b0;
        ev_valid_c   = 1'b0;
        pop_c        = 1'b0;
        push_c       = 1'b0;
        grant_c      = 1'b0;
        ram_we_c     = 1'b0;
        ram_wa_c     = sweep_q;
        ram_wd_c     = 1'b0;
        count_d      = count_q;

        fifo_empty_c = (count_q == '0);
        fifo_full_c  = (count_q == CW'(FIFO_DEPTH));
        ev_valid_c   = sprcoll && (state_q != ST_INIT);
        pop_c        = (state_q != ST_INIT) && !fifo_empty_c;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push_c       = ev_valid_c && (!fifo_full_c || pop_c);
        grant_c      = (state_q == ST_IDLE) && fifo_empty_c && cpu_req;

        if (state_q == ST_INIT) begin
            ram_we_c = 1'b1;
            ram_wa_c = sweep_q;
            ram_wd_c = 1'b0;
        end else if (pop_c) begin
            ram_we_c = 1'b1;
            ram_wa_c = fifo_mem_q[rd_ptr_q];
            ram_wd_c = 1'b1;
        end else if (grant_c && cpu_wr) begin
            ram_we_c = 1'b1;
            ram_wa_c = cpu_ad;
            ram_wd_c = 1'b0;
        end

        count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    // Control FSM: sweep, idle/grant, ack; CPU-facing outputs are registered here.
    always_ff @(posedge VCLKx4 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_INIT;
            sweep_q   <= '0;
            cpu_ack_q <= 1'b0;
            cpu_rdt_q <= 8'hFF;
            busy_q    <= 1'b1;
        end else begin
            cpu_ack_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + AW'(1);
                    if (sweep_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (grant_c) begin
                        state_q   <= ST_ACK;
                        cpu_ack_q <= 1'b1;
                        if (!cpu_wr) begin
                            cpu_rdt_q <= {7'h7F, ram_q[cpu_ad]};
                        end
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Event FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge VCLKx4 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + FAW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + FAW'(1);
            end
            if (ev_valid_c && !push_c) begin
                ovf_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Event FIFO storage; contents are qualified by count_q so need no reset.
    always_ff @(posedge VCLKx4) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= sprcoll_ad;
        end
    end

    // Collision store write port; cleared by the sweep rather than by reset.
    always_ff @(posedge VCLKx4) begin
        if (ram_we_c) begin
            ram_q[ram_wa_c] <= ram_wd_c;
        end
    end

`ifdef SPRCOLL_SUMMARY_EN
    logic coll_any_q;

    // Sticky summary: any accepted event sets it; a set beats a same-cycle clear.
    always_ff @(posedge VCLKx4 or negedge RESET_N) begin
        if (!RESET_N) begin
            coll_any_q <= 1'b0;
        end else if (push_c) begin
            coll_any_q <= 1'b1;
        end else if (cpu_sum_clr) begin
            coll_any_q <= 1'b0;
        end
    end

    assign coll_any = coll_any_q;

    // ovf is kept for debug visibility only; no port carries it.
    logic unused_c;
    assign unused_c = ovf_q;
`else
    assign coll_any = 1'b0;

    // ovf is debug-only and the summary clear has no register to act on.
    logic unused_c;
    assign unused_c = ^{ovf_q, cpu_sum_clr};
`endif

    assign cpu_ack = cpu_ack_q;
    assign cpu_rdt = cpu_rdt_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_segasys1_sprcoll_ram.sv
// Self-checking bench for segasys1_sprcoll_ram: a driver issues events and CPU accesses,
// pushing expected acknowledgements into a queue; a monitor pops and compares on cpu_ack.
// The store is modelled as a plain 1024-entry bit array.
module tb_segasys1_sprcoll_ram;

    logic       clk;
    logic       RESET_N;
    logic       sprcoll;
    logic [9:0] sprcoll_ad;
    logic       cpu_req;
    logic       cpu_wr;
    logic [9:0] cpu_ad;
    logic       cpu_ack;
    logic [7:0] cpu_rdt;
    logic       busy;
    logic       coll_any;
    logic       cpu_sum_clr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       is_rd;
        logic [7:0] rdt;
    } exp_t;

    exp_t exp_q[$];
    bit   model [1024];

`ifdef SPRCOLL_SUMMARY_EN
    localparam bit SUM = 1'b1;
`else
    localparam bit SUM = 1'b0;
`endif

    segasys1_sprcoll_ram #(.FIFO_DEPTH(4)) dut (
        .VCLKx4     (clk),
        .RESET_N    (RESET_N),
        .sprcoll    (sprcoll),
        .sprcoll_ad (sprcoll_ad),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_ad     (cpu_ad),
        .cpu_ack    (cpu_ack),
        .cpu_rdt    (cpu_rdt),
        .busy       (busy),
        .coll_any   (coll_any),
        .cpu_sum_clr(cpu_sum_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every acknowledge must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got cpu_ack=1 expected no ack (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_rd) begin
                        check("cpu_rdt", 32'(cpu_rdt), 32'(e.rdt));
                    end
                end
            end
        end
    end

    // Count cycles from reset release until busy falls; optionally fire an event mid-sweep.
    task automatic sweep_count(output int n, input bit inject);
        n = 0;
        while (n < 1100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            sprcoll    = inject && (n == 100);
            sprcoll_ad = 10'h005;
            if (busy === 1'b0) break;
        end
        sprcoll = 1'b0;
    endtask

    // One CPU access; optional concurrent event to a different address.
    task automatic cpu_op(input bit wr, input logic [9:0] ad, input bit chk_lat,
                          input bit ev, input logic [9:0] ev_ad);
        exp_t e;
        int   cyc;
        repeat (2) @(negedge clk);
        e.is_rd = !wr;
        e.rdt   = {7'h7F, model[ad]};
        exp_q.push_back(e);
        if (wr) model[ad] = 1'b0;
        if (ev) model[ev_ad] = 1'b1;
        cpu_req    = 1'b1;
        cpu_wr     = wr;
        cpu_ad     = ad;
        sprcoll    = ev;
        sprcoll_ad = ev_ad;
        cyc = 0;
        do begin
            @(negedge clk);
            sprcoll = 1'b0;
            cyc++;
        end while (cpu_ack !== 1'b1 && cyc < 20);
        cpu_req = 1'b0;
        if (cpu_ack !== 1'b1) begin
            check("ack_timeout", 32'(cyc), 32'(0));
        end else if (chk_lat) begin
            check("ack_latency", 32'(cyc), 32'(1));
        end
    endtask

    task automatic send_event(input logic [9:0] ad);
        @(negedge clk);
        model[ad]  = 1'b1;
        sprcoll    = 1'b1;
        sprcoll_ad = ad;
        @(negedge clk);
        sprcoll    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;
        int first;
        exp_t e;

        RESET_N = 1'b0; sprcoll = 1'b0; sprcoll_ad = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_ad = '0; cpu_sum_clr = 1'b0;
        foreach (model[i]) model[i] = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_ack", 32'(cpu_ack), 32'(0));
        check("rst_rdt", 32'(cpu_rdt), 32'(8'hFF));
        check("rst_coll_any", 32'(coll_any), 32'(0));

        // Sweep length, with an event during the sweep that must be discarded
        RESET_N = 1'b1;
        sweep_count(n, 1'b1);
        check("sweep_len", 32'(n), 32'(1024));

        // Fresh store reads zero; discarded event left no mark
        cpu_op(1'b0, 10'h155, 1'b1, 1'b0, '0);
        cpu_op(1'b0, 10'h005, 1'b1, 1'b0, '0);

        // Single event then reads of the hit entry and its neighbour
        send_event(10'h123);
        check("coll_any_after_event", 32'(coll_any), 32'(SUM));
        cpu_op(1'b0, 10'h123, 1'b1, 1'b0, '0);
        cpu_op(1'b0, 10'h124, 1'b1, 1'b0, '0);

        // Clear then re-read
        cpu_op(1'b1, 10'h123, 1'b1, 1'b0, '0);
        cpu_op(1'b0, 10'h123, 1'b1, 1'b0, '0);

        // Held read while four events arrive every other cycle
        repeat (2) @(negedge clk);
        e.is_rd = 1'b1;
        e.rdt   = {7'h7F, model[10'h200]};
        exp_q.push_back(e);
        acks = 0;
        first = -1;
        for (int c = 0; c < 12; c++) begin
            sprcoll    = (c % 2 == 0) && (c < 8);
            sprcoll_ad = 10'(10'h010 + c / 2);
            if (sprcoll) model[sprcoll_ad] = 1'b1;
            if (c == 1) begin
                cpu_req = 1'b1;
                cpu_wr  = 1'b0;
                cpu_ad  = 10'h200;
            end
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                acks++;
                if (first < 0) first = c;
                cpu_req = 1'b0;
            end
        end
        sprcoll = 1'b0;
        check("held_ack_count", 32'(acks), 32'(1));
        check("held_grant_cycle", 32'(first), 32'(2));
        for (int a = 16; a < 20; a++) begin
            cpu_op(1'b0, 10'(a), 1'b1, 1'b0, '0);
        end

        // Summary flag: clear alone, then clear colliding with an event
        @(negedge clk);
        cpu_sum_clr = 1'b1;
        @(negedge clk);
        cpu_sum_clr = 1'b0;
        check("sum_clr_alone", 32'(coll_any), 32'(0));
        model[10'h300] = 1'b1;
        sprcoll     = 1'b1;
        sprcoll_ad  = 10'h300;
        cpu_sum_clr = 1'b1;
        @(negedge clk);
        sprcoll     = 1'b0;
        cpu_sum_clr = 1'b0;
        check("sum_set_wins", 32'(coll_any), 32'(SUM));
        @(negedge clk);
        cpu_sum_clr = 1'b1;
        @(negedge clk);
        cpu_sum_clr = 1'b0;
        check("sum_clr_again", 32'(coll_any), 32'(0));

        // Clear granted in the same edge as an event to the same entry: bit ends set
        repeat (2) @(negedge clk);
        e.is_rd = 1'b0;
        e.rdt   = 8'hFF;
        exp_q.push_back(e);
        model[10'h0AA] = 1'b1;
        cpu_req    = 1'b1;
        cpu_wr     = 1'b1;
        cpu_ad     = 10'h0AA;
        sprcoll    = 1'b1;
        sprcoll_ad = 10'h0AA;
        @(negedge clk);
        sprcoll = 1'b0;
        check("same_addr_ack", 32'(cpu_ack), 32'(1));
        cpu_req = 1'b0;
        cpu_op(1'b0, 10'h0AA, 1'b1, 1'b0, '0);
        cpu_op(1'b0, 10'h300, 1'b1, 1'b0, '0);

        // Randomized mix of events, reads and clears
        for (int k = 0; k < 200; k++) begin
            int r;
            logic [9:0] a;
            logic [9:0] ea;
            r  = $urandom_range(0, 2);
            a  = 10'(10'h040 + $urandom_range(0, 31));
            ea = 10'(10'h060 + $urandom_range(0, 31));
            if (r == 0) begin
                send_event(a);
            end else begin
                cpu_op(r == 2, a, 1'b0, 1'($urandom_range(0, 1)), ea);
            end
        end
        for (int a = 10'h060; a < 10'h064; a++) begin
            cpu_op(1'b0, 10'(a), 1'b1, 1'b0, '0);
        end

        // Reset asserted in the grant cycle of a clear: no ack, sweep restarts
        repeat (2) @(negedge clk);
        cpu_req = 1'b1;
        cpu_wr  = 1'b1;
        cpu_ad  = 10'h011;
        RESET_N = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        check("midrst_busy", 32'(busy), 32'(1));
        check("midrst_ack", 32'(cpu_ack), 32'(0));
        @(negedge clk);
        check("midrst_rdt", 32'(cpu_rdt), 32'(8'hFF));
        foreach (model[i]) model[i] = 1'b0;
        RESET_N = 1'b1;
        sweep_count(n, 1'b0);
        check("resweep_len", 32'(n), 32'(1024));
        check("resweep_coll_any", 32'(coll_any), 32'(0));
        cpu_op(1'b0, 10'h011, 1'b1, 1'b0, '0);
        cpu_op(1'b0, 10'h0AA, 1'b1, 1'b0, '0);

        repeat (4) @(negedge clk);
        check("outstanding_expect", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
